// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker that locks onto the G/Y/R light sequence and flags encoding, sequence and dwell errors
// Optional dwell checking is built only when TLM_DWELL_CHECK_EN is defined.
module traffic_light_monitor #(
  parameter int unsigned GREEN_CYCLES  = 2,
  parameter int unsigned YELLOW_CYCLES = 1,
  parameter int unsigned RED_CYCLES    = 2,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 green,
  input  logic                 yellow,
  input  logic                 red,
  input  logic                 clear_err,
  output logic [1:0]           phase,
  output logic                 locked,
  output logic                 period_done,
  output logic                 err_encoding,
  output logic                 err_sequence,
  output logic                 err_dwell,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_UNSYNC = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10,
    S_RED    = 2'b11
  } state_t;

  state_t                 r_state, w_state_nxt;
  state_t                 r_prev_col, w_col;
  logic                   r_prev_valid;
  logic                   w_valid;
  logic                   w_enc, w_seq, w_dw, w_pd, w_any;
  logic                   w_dw_over, w_dw_under;
  logic                   r_pd, r_enc, r_seq, r_dw;
  logic [ERR_CNT_W-1:0]   r_err_count;

  function automatic state_t next_col(input state_t s);
    case (s)
      S_GREEN:  return S_YELLOW;
      S_YELLOW: return S_RED;
      S_RED:    return S_GREEN;
      default:  return S_UNSYNC;
    endcase
  endfunction

  // One-hot test: odd number of lines set, but not all three.
  assign w_valid = (green ^ yellow ^ red) & ~(green & yellow & red);

  always_comb begin
    w_col = S_RED;
    if (green)       w_col = S_GREEN;
    else if (yellow) w_col = S_YELLOW;
  end

`ifdef TLM_DWELL_CHECK_EN
  logic [CNT_W-1:0] r_dwell, w_dwell_nxt, w_exp;

  always_comb begin
    w_exp = '0;
    case (r_state)
      S_GREEN:  w_exp = CNT_W'(GREEN_CYCLES);
      S_YELLOW: w_exp = CNT_W'(YELLOW_CYCLES);
      S_RED:    w_exp = CNT_W'(RED_CYCLES);
      default:  w_exp = '0;
    endcase
  end

  // r_dwell equals expected only once per phase, so overstay pulses a single time.
  assign w_dw_over  = (r_dwell == w_exp);
  assign w_dw_under = (r_dwell < w_exp);

  always_comb begin
    w_dwell_nxt = r_dwell;
    if (w_state_nxt == S_UNSYNC)     w_dwell_nxt = '0;
    else if (w_state_nxt != r_state) w_dwell_nxt = CNT_W'(1);
    else if (r_dwell != '1)          w_dwell_nxt = r_dwell + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_dwell <= '0;
    else        r_dwell <= w_dwell_nxt;
  end
`else
  assign w_dw_over  = 1'b0;
  assign w_dw_under = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_enc       = 1'b0;
    w_seq       = 1'b0;
    w_dw        = 1'b0;
    w_pd        = 1'b0;
    if (!w_valid) begin
      w_enc       = 1'b1;
      w_state_nxt = S_UNSYNC;
    end else if (r_state == S_UNSYNC) begin
      if (w_col == S_GREEN && r_prev_valid && r_prev_col == S_RED)
        w_state_nxt = S_GREEN;
    end else if (w_col == r_state) begin
      w_dw = w_dw_over;
    end else if (w_col == next_col(r_state)) begin
      w_dw        = w_dw_under;
      w_pd        = (r_state == S_RED);
      w_state_nxt = w_col;
    end else begin
      w_seq       = 1'b1;
      w_state_nxt = S_UNSYNC;
    end
  end

  assign w_any = w_enc | w_seq | w_dw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_UNSYNC;
      r_prev_col   <= S_UNSYNC;
      r_prev_valid <= 1'b0;
      r_pd         <= 1'b0;
      r_enc        <= 1'b0;
      r_seq        <= 1'b0;
      r_dw         <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_col   <= w_col;
      r_prev_valid <= w_valid;
      r_pd         <= w_pd;
      r_enc        <= w_enc;
      r_seq        <= w_seq;
      r_dw         <= w_dw;
      if (clear_err)
        r_err_count <= w_any ? ERR_CNT_W'(1) : '0;
      else if (w_any && r_err_count != '1)
        r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign phase        = r_state;
  assign locked       = (r_state != S_UNSYNC);
  assign period_done  = r_pd;
  assign err_encoding = r_enc;
  assign err_sequence = r_seq;
  assign err_dwell    = r_dw;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - scoreboard bench for traffic_light_monitor with directed light patterns
module tb_traffic_light_monitor;

`ifdef TLM_DWELL_CHECK_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif

  localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001, GY = 3'b110, NONE = 3'b000;
  localparam logic [2:0] OK = 3'b000, E_ENC = 3'b100, E_SEQ = 3'b010, E_DW = 3'b001;

  logic clk = 1'b0;
  logic reset, green, yellow, red, clear_err;
  logic [1:0] phase, phase2;
  logic locked, period_done, err_encoding, err_sequence, err_dwell;
  logic locked2, period_done2, err_encoding2, err_sequence2, err_dwell2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  typedef struct {
    logic [1:0] ph;
    logic       pd;
    logic       enc;
    logic       seq;
    logic       dw;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int exp_cnt2 = 0;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .green(green), .yellow(yellow), .red(red),
    .clear_err(clear_err), .phase(phase), .locked(locked), .period_done(period_done),
    .err_encoding(err_encoding), .err_sequence(err_sequence), .err_dwell(err_dwell),
    .err_count(err_count)
  );

  traffic_light_monitor #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .green(green), .yellow(yellow), .red(red),
    .clear_err(clear_err), .phase(phase2), .locked(locked2), .period_done(period_done2),
    .err_encoding(err_encoding2), .err_sequence(err_sequence2), .err_dwell(err_dwell2),
    .err_count(err_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one sample at a falling edge and queue what the outputs must show after the next rising edge.
  task automatic step(input logic [2:0] gyr, input logic [1:0] ph, input logic pd,
                      input logic [2:0] err, input logic clr = 1'b0);
    exp_t e;
    logic any;
    {green, yellow, red} = gyr;
    clear_err = clr;
    e.ph  = ph;
    e.pd  = pd;
    e.enc = err[2];
    e.seq = err[1];
    e.dw  = err[0] & DW_EN;
    any   = e.enc | e.seq | e.dw;
    if (clr) begin
      exp_cnt  = any ? 1 : 0;
      exp_cnt2 = any ? 1 : 0;
    end else if (any) begin
      if (exp_cnt != 255) exp_cnt++;
      if (exp_cnt2 != 3) exp_cnt2++;
    end
    e.cnt  = 8'(exp_cnt);
    e.cnt2 = 2'(exp_cnt2);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_period_done"}, period_done, 0);
    chk({tag, "_err_encoding"}, err_encoding, 0);
    chk({tag, "_err_sequence"}, err_sequence, 0);
    chk({tag, "_err_dwell"}, err_dwell, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_err_count2"}, err_count2, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("phase", phase, e.ph);
        chk("locked", locked, (e.ph != 2'b00));
        chk("period_done", period_done, e.pd);
        chk("err_encoding", err_encoding, e.enc);
        chk("err_sequence", err_sequence, e.seq);
        chk("err_dwell", err_dwell, e.dw);
        chk("err_count", err_count, e.cnt);
        chk("err_count_w2", err_count2, e.cnt2);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b0;
    {green, yellow, red} = NONE;
    clear_err = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // Acquire lock from R,R then twenty nominal periods.
    step(R, 2'd0, 0, OK);
    step(R, 2'd0, 0, OK);
    for (int p = 0; p < 20; p++) begin
      step(G, 2'd1, (p > 0), OK);
      step(G, 2'd1, 0, OK);
      step(Y, 2'd2, 0, OK);
      step(R, 2'd3, 0, OK);
      step(R, 2'd3, 0, OK);
    end

    // Green overstay on the third G, then a green understay caught on Y.
    step(G, 2'd1, 1, OK);
    step(G, 2'd1, 0, OK);
    step(G, 2'd1, 0, E_DW);
    step(Y, 2'd2, 0, OK);
    step(R, 2'd3, 0, OK);
    step(R, 2'd3, 0, OK);
    step(G, 2'd1, 1, OK);
    step(Y, 2'd2, 0, E_DW);
    step(R, 2'd3, 0, OK);
    step(R, 2'd3, 0, OK);
    step(G, 2'd1, 1, OK);
    step(G, 2'd1, 0, OK);
    step(Y, 2'd2, 0, OK);
    step(R, 2'd3, 0, OK);
    step(R, 2'd3, 0, OK);

    // Illegal G->R, then the R->G pair relocks cleanly.
    step(G, 2'd1, 1, OK);
    step(R, 2'd0, 0, E_SEQ);
    step(G, 2'd1, 0, OK);
    step(G, 2'd1, 0, OK);
    step(Y, 2'd2, 0, OK);
    step(R, 2'd3, 0, OK);
    step(R, 2'd3, 0, OK);
    step(G, 2'd1, 1, OK);
    step(G, 2'd1, 0, OK);
    step(Y, 2'd2, 0, OK);
    step(R, 2'd3, 0, OK);
    step(R, 2'd3, 0, OK);

    // Two bad encodings; neither may lock, and G after them stays unsynced.
    step(GY, 2'd0, 0, E_ENC);
    step(NONE, 2'd0, 0, E_ENC);
    step(G, 2'd0, 0, OK);
    step(R, 2'd0, 0, OK);
    step(G, 2'd1, 0, OK);
    step(G, 2'd1, 0, OK);
    step(Y, 2'd2, 0, OK);
    step(R, 2'd3, 0, OK);
    step(R, 2'd3, 0, OK);

    // Saturate the 2-bit counter, clear with a coincident error, then clear alone.
    for (int i = 0; i < 5; i++) step(3'b111, 2'd0, 0, E_ENC);
    step(3'b011, 2'd0, 0, E_ENC, 1'b1);
    step(R, 2'd0, 0, OK, 1'b1);
    step(G, 2'd1, 0, OK);
    step(G, 2'd1, 0, OK);
    step(Y, 2'd2, 0, OK);

    // Asynchronous reset between edges while in yellow.
    {green, yellow, red} = R;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("queue_empty_mid", q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;
    exp_cnt2 = 0;
    step(G, 2'd0, 0, OK);
    step(R, 2'd0, 0, OK);
    step(G, 2'd1, 0, OK);
    step(G, 2'd1, 0, OK);
    step(Y, 2'd2, 0, OK);
    step(R, 2'd3, 0, OK);
    step(R, 2'd3, 0, OK);
    step(G, 2'd1, 1, OK);

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker at the observing end of the traffic-light controller outputs. It samples the `green`/`yellow`/`red` lines every clock and decodes them back into a phase. It locks onto the GREEN→YELLOW→RED cycle and flags illegal encodings, illegal phase transitions and wrong phase dwell times. It sits beside the controller in the top level and drives status and error outputs only; it never drives the lights.

## Interface
- `GREEN_CYCLES`, default 2: required consecutive green samples per period.
- `YELLOW_CYCLES`, default 1: required consecutive yellow samples.
- `RED_CYCLES`, default 2: required consecutive red samples.
- `CNT_W`, default 4: dwell counter width; must hold max(*_CYCLES)+1.
- `ERR_CNT_W`, default 8: error counter width.

- `clk`  input  1: single clock, rising edge.
- `reset`  input  1: reset; asynchronous, active-low (0 = reset).
- `green`  input  1: observed green light.
- `yellow`  input  1: observed yellow light.
- `red`  input  1: observed red light.
- `clear_err`  input  1: synchronous clear of `err_count`.
- `phase`  output  2: decoded phase; 00 unsynced, 01 green, 10 yellow, 11 red.
- `locked`  output  1: tracking a legal sequence.
- `period_done`  output  1: one-cycle pulse on each legal RED→GREEN while locked.
- `err_encoding`  output  1: one-cycle pulse; the sample was not one-hot.
- `err_sequence`  output  1: one-cycle pulse; the sample showed an illegal colour transition.
- `err_dwell`  output  1: one-cycle pulse; phase too short or too long.
- `err_count`  output  `ERR_CNT_W`: saturating count of error pulses.

## Operation
- A sample is valid when exactly one of g/y/r is 1. The block keeps the previous sample (`prev`); reset sets `prev` to invalid.
- States: UNSYNC, GREEN, YELLOW, RED. `phase` encodes the state; `locked` = state ≠ UNSYNC.
- UNSYNC: a valid green sample with `prev` = valid red moves the state to GREEN with dwell=1. Any other sample leaves the state in UNSYNC. No sequence or dwell errors are raised while in UNSYNC.
- Locked, same colour as the current state: dwell increments, saturating at all-ones. When dwell reaches expected+1, `err_dwell` pulses once (overstay); further samples of the same colour do not pulse again.
- Locked, next legal colour (G→Y, Y→R, R→G): if dwell < expected, `err_dwell` pulses (understay). The state advances and dwell=1. R→G also pulses `period_done`.
- Locked, other valid colour (G→R, Y→G, R→Y): `err_sequence` pulses, the state goes to UNSYNC and dwell=0. No dwell check applies on this sample.
- Invalid sample (any state): `err_encoding` pulses. If locked, the state goes to UNSYNC.
- At most one error pulse per sample. Priority: encoding > sequence > dwell.
- `err_count` increments on any error pulse and saturates at 2^ERR_CNT_W−1.
- If `clear_err` and an error pulse occur on the same edge, the result is 1. `clear_err` alone gives 0.

## Timing
- All outputs are registered. An output reflecting the sample taken at edge k is valid from edge k until edge k+1 (one-cycle latency from input change to flag).
- Relock after any error: earliest at the first R→G pair, i.e. two valid samples.
- Reset values: `phase`=00, `locked`=0, all pulses 0, `err_count`=0, dwell=0, `prev`=invalid.
- Reset asserted mid-operation clears all outputs immediately, without waiting for `clk`. After release, the block must relock from UNSYNC.
- The `*_CYCLES` parameters must each be ≥1. Dwell comparisons are unsigned at `CNT_W` bits.

## Configuration
- `TLM_DWELL_CHECK_EN` defined: dwell counter and `err_dwell` are implemented as above.
- `TLM_DWELL_CHECK_EN` undefined:
  - Dwell counter is removed and `err_dwell` is tied to 0.
  - Dwell never contributes to `err_count`.
  - Encoding and sequence checks, locking and `period_done` are unchanged.

## Test plan
All scenarios use default parameters, with the nominal pattern G,G,Y,R,R repeating.
- Reset, then drive R,R followed by the nominal pattern → `locked`=1 and `phase`=01 one cycle after the first G. `period_done` pulses every 5 cycles. All error flags stay 0 over 20 periods.
- While locked, hold G for 3 samples → `err_dwell` pulses once on the 3rd G, `err_count`=1, `locked` stays 1. Repeat with a single G → `err_dwell` pulses on the Y sample.
- While locked, drive G then R → `err_sequence` pulses, `locked`=0, `phase`=00. The next R→G relocks with no further errors.
- Drive g=y=1, then g=y=r=0 → `err_encoding` pulses on each sample and `err_count` rises by 2. Neither sample locks the block.
- With `ERR_CNT_W`=2, inject 5 encoding errors → `err_count` holds at 3. Assert `clear_err` together with a 6th error → `err_count`=1.
- Assert `reset` low mid-yellow between clock edges → all outputs are 0 before the next edge. After release, the block stays UNSYNC until an R→G pair.
